// File: rtl/invpre_stream.sv
// invpre_stream: streaming inverse preprocessor.
//
// Rebuilds samples from mapped prediction residuals produced by the Rice
// decoder. A unit-delay predictor (x_hat = previous sample) is inverted
// through the residual mapping. Every R blocks of J samples a raw
// reference sample is inserted instead of a residual.
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_sync   input stream; in_sync marks a segment start
//   pre_en        1 = inverse mapping, 0 = bypass (sampled on the sync accept)
//   err_clr       clears the sticky err_sync flag
//   out_valid/out_ready/out_data        output stream (single output register)
//   out_ref       out_data is a raw reference sample
//   out_last      out_data is the last sample of a J-block
//   err_sync      sticky framing error (word before first sync, mid-block resync)
//   dbg_state_o   current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: a word transfers on a side when valid && ready are both high at
// a rising clock edge. valid never depends on ready; once out_valid is high
// out_data/out_ref/out_last hold until the sink takes them. in_ready is
// !out_valid || out_ready, so a pop and a push in the same cycle reload the
// output register without a bubble.
module invpre_stream #(
  parameter int N      = 16,
  parameter int J      = 16,
  parameter int R      = 128,
  parameter int SIGNED = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_sync,
  input  logic         pre_en,
  input  logic         err_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ref,
  output logic         out_last,
  output logic         err_sync,
  output logic         dbg_state_o
);

  localparam int W  = N + 2;
  localparam int SW = $clog2(J);
  localparam int BW = (R > 1) ? $clog2(R) : 1;

  localparam logic [SW-1:0] S_LAST = SW'(J - 1);
  localparam logic [BW-1:0] B_LAST = BW'(R - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic signed [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};
  localparam logic signed [W-1:0] XMIN  = (SIGNED != 0) ? -(ONE_W <<< (N - 1)) : '0;
  localparam logic signed [W-1:0] XMAX  = (SIGNED != 0) ? ((ONE_W <<< (N - 1)) - ONE_W)
                                                        : ((ONE_W <<< N) - ONE_W);

  // State registers
  logic [0:0]    state_q, state_d;
  logic [SW-1:0] s_idx_q, s_idx_d;
  logic [BW-1:0] b_idx_q, b_idx_d;
  logic [N-1:0]  xhat_q, xhat_d;
  logic          mode_q, mode_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_ref_q, out_ref_d;
  logic          out_last_q, out_last_d;
  logic          err_q, err_d;

  // Datapath
  logic                accept;
  logic [SW-1:0]       s_cur, s_nxt;
  logic [BW-1:0]       b_cur, b_nxt;
  logic                is_ref;
  logic                mode_eff;
  logic signed [W-1:0] xhat_w, d_w, lo_gap, hi_gap, theta, delta, x_w;
  logic [N-1:0]        x_map, x_new;

  assign in_ready    = !out_valid_q || out_ready;
  assign accept      = in_valid && in_ready;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_ref     = out_ref_q;
  assign out_last    = out_last_q;
  assign err_sync    = err_q;
  assign dbg_state_o = state_q;

  // A sync word restarts the counters for itself, so position and reference
  // status are derived from the restarted values, not the registered ones.
  assign s_cur    = in_sync ? '0 : s_idx_q;
  assign b_cur    = in_sync ? '0 : b_idx_q;
  assign is_ref   = (s_cur == '0) && (b_cur == '0);
  assign mode_eff = in_sync ? pre_en : mode_q;

  assign s_nxt = (s_cur == S_LAST) ? '0 : s_cur + SW'(1);
  assign b_nxt = (s_cur != S_LAST) ? b_cur :
                 ((b_cur == B_LAST) ? '0 : b_cur + BW'(1));

  assign xhat_w = (SIGNED != 0) ? {{2{xhat_q[N-1]}}, xhat_q} : {2'b00, xhat_q};
  assign d_w    = $signed({2'b00, in_data});

  // Inverse residual mapping. Small residuals alternate around x_hat
  // (even = up, odd = down); past 2*theta the near side of the range is
  // exhausted and the residual walks away from the closer bound.
  always_comb begin
    lo_gap = xhat_w - XMIN;
    hi_gap = XMAX - xhat_w;
    theta  = (lo_gap < hi_gap) ? lo_gap : hi_gap;
    if (d_w <= (theta <<< 1)) begin
      if (d_w[0] == 1'b0) delta = d_w >>> 1;
      else                delta = -((d_w + ONE_W) >>> 1);
    end else if (theta == lo_gap) begin
      delta = d_w - theta;
    end else begin
      delta = theta - d_w;
    end
    x_w = xhat_w + delta;
    // Clamp only matters for residuals beyond the representable span.
    if (x_w < XMIN)      x_map = XMIN[N-1:0];
    else if (x_w > XMAX) x_map = XMAX[N-1:0];
    else                 x_map = x_w[N-1:0];
  end

  assign x_new = (is_ref || !mode_eff) ? in_data : x_map;

  always_comb begin
    state_d     = state_q;
    s_idx_d     = s_idx_q;
    b_idx_d     = b_idx_q;
    xhat_d      = xhat_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ref_d   = out_ref_q;
    out_last_d  = out_last_q;
    // A new error in the same cycle as err_clr wins below.
    err_d       = err_q && !err_clr;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if ((state_q == IDLE) && !in_sync) begin
        // Unframed word: drop it and flag the framing error.
        err_d = 1'b1;
      end else begin
        state_d = RUN;
        if (in_sync && (state_q == RUN) && (s_idx_q != '0)) err_d = 1'b1;
        if (in_sync) mode_d = pre_en;
        out_valid_d = 1'b1;
        out_data_d  = x_new;
        out_ref_d   = is_ref;
        out_last_d  = (s_cur == S_LAST);
        xhat_d      = x_new;
        s_idx_d     = s_nxt;
        b_idx_d     = b_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      s_idx_q     <= '0;
      b_idx_q     <= '0;
      xhat_q      <= '0;
      mode_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ref_q   <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_idx_q     <= s_idx_d;
      b_idx_q     <= b_idx_d;
      xhat_q      <= xhat_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ref_q   <= out_ref_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_invpre_stream.sv
// Testbench for invpre_stream: unsigned (N=8) and signed (N=8) instances
// with J=8, R=2 share one input stream; each has its own output monitor.
module tb_invpre_stream;

  localparam int N = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         in_sync = 1'b0;
  logic         pre_en = 1'b1;
  logic         err_clr = 1'b0;
  logic         out_ready = 1'b1;

  logic         in_ready, out_valid, out_ref, out_last, err_sync, dbg_state;
  logic [N-1:0] out_data;
  logic         s_in_ready, s_out_valid, s_out_ref, s_out_last, s_err_sync, s_dbg_state;
  logic [N-1:0] s_out_data;

  invpre_stream #(.N(N), .J(8), .R(2), .SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sync(in_sync), .pre_en(pre_en), .err_clr(err_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ref(out_ref), .out_last(out_last), .err_sync(err_sync),
    .dbg_state_o(dbg_state)
  );

  invpre_stream #(.N(N), .J(8), .R(2), .SIGNED(1)) u_sdut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_sync(in_sync), .pre_en(pre_en), .err_clr(err_clr),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_ref(s_out_ref), .out_last(s_out_last), .err_sync(s_err_sync),
    .dbg_state_o(s_dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Scoreboard queues
  logic [N-1:0] exp_q[$];
  logic [N-1:0] got_q[$];
  logic         got_ref_q[$];
  logic         got_last_q[$];
  int           got_cyc_q[$];
  logic [N-1:0] sgot_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_ref_q.push_back(out_ref);
      got_last_q.push_back(out_last);
      got_cyc_q.push_back(cyc);
    end
    if (s_out_valid && out_ready) sgot_q.push_back(s_out_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic clear_q();
    exp_q.delete(); got_q.delete(); got_ref_q.delete();
    got_last_q.delete(); got_cyc_q.delete(); sgot_q.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sync = 1'b0; in_data = '0;
    pre_en = 1'b1; err_clr = 1'b0; out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_q();
  endtask

  task automatic push(input logic [N-1:0] d, input logic sync);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_sync = sync;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0; in_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference inverse mapping for N=8 unsigned.
  function automatic int inv_map(input int xh, input int d);
    int th;
    th = (xh < 255 - xh) ? xh : 255 - xh;
    if (d <= 2 * th) begin
      if (d % 2 == 0) return xh + d / 2;
      return xh - (d + 1) / 2;
    end
    if (th == xh) return d;
    return 255 - d;
  endfunction

  // Tests
  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_ref, out_last, err_sync} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000", {out_valid, out_ref, out_last, err_sync});
    end
    checks++;
    if (out_data !== 8'd0) begin
      errors++; $display("FAIL reset_data: got %0d required 0", out_data);
    end
    checks++;
    if (in_ready !== 1'b1 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_state: in_ready=%b state=%b required 1/0", in_ready, dbg_state);
    end
    do_reset();
  endtask

  task automatic test_map_basic();
    logic [N-1:0] exp_d [5];
    logic         exp_r [5];
    exp_d = '{8'd100, 8'd100, 8'd99, 8'd100, 8'd98};
    exp_r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    push(8'd100, 1'b1);
    push(8'd0, 1'b0); push(8'd1, 1'b0); push(8'd2, 1'b0); push(8'd3, 1'b0);
    idle(3);
    checks++;
    if (got_q.size() != 5) begin
      errors++; $display("FAIL basic_count: got %0d required 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_q[i] !== exp_d[i] || got_ref_q[i] !== exp_r[i]) begin
          errors++;
          $display("FAIL basic_word%0d: got data=%0d ref=%b required data=%0d ref=%b",
                   i, got_q[i], got_ref_q[i], exp_d[i], exp_r[i]);
        end
      end
    end
  endtask

  task automatic test_map_edges();
    do_reset();
    push(8'd250, 1'b1); push(8'd20, 1'b0);
    idle(3);
    checks++;
    if (got_q.size() != 2 || got_q[1] !== 8'd235) begin
      errors++; $display("FAIL edge_high: got %0d required 235", got_q[1]);
    end
    do_reset();
    push(8'd3, 1'b1); push(8'd10, 1'b0);
    idle(3);
    checks++;
    if (got_q.size() != 2 || got_q[1] !== 8'd10) begin
      errors++; $display("FAIL edge_low: got %0d required 10", got_q[1]);
    end
    do_reset();
    push(8'd0, 1'b1); push(8'd0, 1'b0); push(8'd1, 1'b0);
    idle(3);
    checks++;
    if (got_q.size() != 3 || got_q[1] !== 8'd0 || got_q[2] !== 8'd1) begin
      errors++; $display("FAIL edge_zero: got %0d,%0d required 0,1", got_q[1], got_q[2]);
    end
  endtask

  task automatic test_signed();
    do_reset();
    push(8'h80, 1'b1); push(8'd5, 1'b0);
    idle(3);
    checks++;
    if (sgot_q.size() != 2 || sgot_q[1] !== 8'h85) begin
      errors++; $display("FAIL signed_min: got %0d required %0d", $signed(sgot_q[1]), -123);
    end
    do_reset();
    push(8'h7F, 1'b1); push(8'd9, 1'b0);
    idle(3);
    checks++;
    if (sgot_q.size() != 2 || sgot_q[1] !== 8'd118) begin
      errors++; $display("FAIL signed_max: got %0d required 118", $signed(sgot_q[1]));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pre_en = 1'b0;
    push(8'd0, 1'b1);
    for (int i = 1; i < 40; i++) push(8'(i), 1'b0);
    idle(3);
    checks++;
    if (got_q.size() != 40) begin
      errors++; $display("FAIL b2b_count: got %0d required 40", got_q.size());
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (got_q[i] !== 8'(i) || got_ref_q[i] !== (i % 16 == 0) ||
            got_last_q[i] !== (i % 8 == 7) ||
            (i > 0 && got_cyc_q[i] != got_cyc_q[i-1] + 1)) begin
          errors++;
          $display("FAIL b2b_word%0d: got data=%0d ref=%b last=%b gap=%0d required data=%0d ref=%b last=%b gap=1",
                   i, got_q[i], got_ref_q[i], got_last_q[i],
                   (i > 0) ? got_cyc_q[i] - got_cyc_q[i-1] : 1,
                   i, (i % 16 == 0), (i % 8 == 7));
        end
      end
    end
    pre_en = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] dv [201];
    logic [N-1:0] ev [201];
    logic [N-1:0] g;
    int xh, s, b, x;
    bit is_ref;
    do_reset();
    xh = 0; s = 0; b = 0;
    for (int i = 0; i < 201; i++) begin
      dv[i] = 8'($urandom_range(0, 255));
      is_ref = (s == 0 && b == 0);
      x = is_ref ? int'(dv[i]) : inv_map(xh, int'(dv[i]));
      ev[i] = 8'(x);
      exp_q.push_back(ev[i]);
      xh = x;
      if (s == 7) begin
        s = 0;
        b = (b == 1) ? 0 : b + 1;
      end else begin
        s = s + 1;
      end
    end
    for (int i = 0; i < 201; i++) begin
      if (i == 100) begin
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = dv[100]; in_sync = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== ev[99]) begin
            errors++;
            $display("FAIL stall_hold: in_ready=%b out_valid=%b data=%0d required 0/1/%0d",
                     in_ready, out_valid, out_data, ev[99]);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
      push(dv[i], (i == 0));
    end
    idle(3);
    checks++;
    if (got_q.size() != 201) begin
      errors++; $display("FAIL bp_count: got %0d required 201", got_q.size());
    end
    for (int i = 0; i < 201; i++) begin
      if (exp_q.size() == 0 || got_q.size() == 0) break;
      g = got_q.pop_front();
      checks++;
      if (g !== exp_q[0]) begin
        errors++; $display("FAIL bp_word%0d: got %0d required %0d", i, g, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_errors();
    do_reset();
    push(8'd7, 1'b0); push(8'd9, 1'b0);
    idle(2);
    checks++;
    if (got_q.size() != 0 || err_sync !== 1'b1) begin
      errors++; $display("FAIL idle_drop: outputs=%0d err=%b required 0/1", got_q.size(), err_sync);
    end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    checks++;
    if (err_sync !== 1'b0) begin
      errors++; $display("FAIL err_clr: got %b required 0", err_sync);
    end
    err_clr = 1'b1;
    push(8'd5, 1'b0);
    err_clr = 1'b0;
    checks++;
    if (err_sync !== 1'b1) begin
      errors++; $display("FAIL clr_vs_set: got %b required 1", err_sync);
    end
    do_reset();
    push(8'd10, 1'b1);
    push(8'd0, 1'b0); push(8'd0, 1'b0);
    checks++;
    if (err_sync !== 1'b0) begin
      errors++; $display("FAIL clean_sync: got err=%b required 0", err_sync);
    end
    push(8'd50, 1'b1);
    idle(2);
    checks++;
    if (err_sync !== 1'b1 || got_q.size() != 4 || got_q[3] !== 8'd50 || got_ref_q[3] !== 1'b1) begin
      errors++;
      $display("FAIL resync: err=%b n=%0d data=%0d ref=%b required 1/4/50/1",
               err_sync, got_q.size(), got_q[3], got_ref_q[3]);
    end
  endtask

  task automatic test_reset_midblock();
    do_reset();
    push(8'd20, 1'b1); push(8'd1, 1'b0); push(8'd2, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valid: got %b required 1", out_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || out_ref !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%0d ref=%b required 0/0/0", out_valid, out_data, out_ref);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    clear_q();
    push(8'd33, 1'b0);
    idle(2);
    checks++;
    if (got_q.size() != 0 || err_sync !== 1'b1 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_to_idle: outputs=%0d err=%b state=%b required 0/1/0",
               got_q.size(), err_sync, dbg_state);
    end
    push(8'd44, 1'b1);
    idle(2);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'd44 || got_ref_q[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart_ref: n=%0d data=%0d ref=%b required 1/44/1", got_q.size(), got_q[0], got_ref_q[0]);
    end
  endtask

  // Sequencer and final report
  initial begin
    test_reset();
    test_map_basic();
    test_map_edges();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_reset_midblock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
